// File: rtl/cdu_pulse_scheduler_if.sv
// Signal bundle between the gimbal CDU channels, the AGC slot timing and the pulse scheduler.
// AOVF/BOVF/COVF exist only when CDU_SCHED_OVF_EN is defined.
interface cdu_pulse_scheduler_if;
  logic       SLOTH;
  logic       ApINC, AmINC, BpINC, BmINC, CpINC, CmINC;
  logic       ACDUZ, BCDUZ, CCDUZ;
  logic       ATpPGH, ATmPGH, BTpPGH, BTmPGH, CTpPGH, CTmPGH;
  logic       BUSY;
  logic [1:0] GSEL;
`ifdef CDU_SCHED_OVF_EN
  logic       AOVF, BOVF, COVF;
`endif

  modport master (
    output SLOTH, ApINC, AmINC, BpINC, BmINC, CpINC, CmINC, ACDUZ, BCDUZ, CCDUZ,
    input  ATpPGH, ATmPGH, BTpPGH, BTmPGH, CTpPGH, CTmPGH, BUSY, GSEL
`ifdef CDU_SCHED_OVF_EN
    , input AOVF, BOVF, COVF
`endif
  );

  modport slave (
    input  SLOTH, ApINC, AmINC, BpINC, BmINC, CpINC, CmINC, ACDUZ, BCDUZ, CCDUZ,
    output ATpPGH, ATmPGH, BTpPGH, BTmPGH, CTpPGH, CTmPGH, BUSY, GSEL
`ifdef CDU_SCHED_OVF_EN
    , output AOVF, BOVF, COVF
`endif
  );
endinterface

// File: rtl/cdu_pulse_scheduler.sv
// Three-channel CDU pulse scheduler: per-channel saturating pending-pulse accumulators drained
// round-robin into fixed-width AGC pulses. Optional sticky overflow flags with CDU_SCHED_OVF_EN.
module cdu_pulse_scheduler #(
  parameter int unsigned CW      = 4,
  parameter int unsigned PULSE_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  cdu_pulse_scheduler_if.slave bus
);
  localparam int unsigned NCH   = 3;
  localparam int unsigned CNT_W = 4;
  localparam int          SAT   = int'((1 << (CW - 1)) - 1);

  typedef enum logic {IDLE, PULSE} state_t;

  logic [NCH-1:0] inc_p, inc_m, zero;
  assign inc_p = {bus.CpINC, bus.BpINC, bus.ApINC};
  assign inc_m = {bus.CmINC, bus.BmINC, bus.AmINC};
  assign zero  = {bus.CCDUZ, bus.BCDUZ, bus.ACDUZ};

  logic signed [CW-1:0] acc_q [NCH];
  logic signed [CW-1:0] acc_d [NCH];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       gsel_q, gsel_d;
  logic [5:0]       out_q, out_d;
  logic             busy_q, busy_d;

  logic [NCH-1:0]   elig_c;
  logic             grant_c;
  logic [1:0]       gch_c;
  logic             gneg_c;
  logic [1:0]       idx_c;

`ifdef CDU_SCHED_OVF_EN
  logic [NCH-1:0]   ovf_q, ovf_d;
`endif

  // A channel competes only with pending pulses and no zero command this cycle.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      elig_c[i] = (acc_q[i] != '0) && !zero[i];
    end
  end

  // Round-robin search starting at rr_q; only meaningful in IDLE with SLOTH high.
  always_comb begin
    grant_c = 1'b0;
    gch_c   = 2'd0;
    gneg_c  = 1'b0;
    idx_c   = 2'd0;
    if (state_q == IDLE && bus.SLOTH) begin
      for (int k = 0; k < int'(NCH); k++) begin
        idx_c = 2'((32'(rr_q) + 32'(k)) % 32'(NCH));
        if (!grant_c && elig_c[idx_c]) begin
          grant_c = 1'b1;
          gch_c   = idx_c;
        end
      end
      if (grant_c) gneg_c = acc_q[gch_c][CW-1];
    end
  end

  // Scheduler next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gsel_d  = gsel_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (grant_c) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(PULSE_W - 1);
          gsel_d  = gch_c;
          rr_d    = (gch_c == 2'd2) ? 2'd0 : gch_c + 2'd1;
          out_d   = '0;
          out_d[{gch_c, gneg_c}] = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          out_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = '0;
      end
    endcase
    busy_d = |out_d;
  end

  // Accumulator update: P + p - m - g, clamped symmetric; zero command wins.
  int sum_c;
  int gval_c;
  always_comb begin
    sum_c  = 0;
    gval_c = 0;
`ifdef CDU_SCHED_OVF_EN
    ovf_d  = ovf_q;
`endif
    for (int unsigned i = 0; i < NCH; i++) begin
      gval_c = 0;
      if (grant_c && (gch_c == 2'(i))) gval_c = gneg_c ? -1 : 1;
      sum_c = int'(acc_q[i]) + int'(inc_p[i]) - int'(inc_m[i]) - gval_c;
      if (zero[i]) begin
        acc_d[i] = '0;
`ifdef CDU_SCHED_OVF_EN
        ovf_d[i] = 1'b0;
`endif
      end else if (sum_c > SAT) begin
        acc_d[i] = CW'(SAT);
`ifdef CDU_SCHED_OVF_EN
        ovf_d[i] = 1'b1;
`endif
      end else if (sum_c < -SAT) begin
        acc_d[i] = CW'(-SAT);
`ifdef CDU_SCHED_OVF_EN
        ovf_d[i] = 1'b1;
`endif
      end else begin
        acc_d[i] = CW'(sum_c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= 2'd0;
      gsel_q  <= 2'd0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) acc_q[i] <= '0;
`ifdef CDU_SCHED_OVF_EN
      ovf_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gsel_q  <= gsel_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      for (int unsigned i = 0; i < NCH; i++) acc_q[i] <= acc_d[i];
`ifdef CDU_SCHED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Output vector is indexed {channel, negative}.
  assign bus.ATpPGH = out_q[0];
  assign bus.ATmPGH = out_q[1];
  assign bus.BTpPGH = out_q[2];
  assign bus.BTmPGH = out_q[3];
  assign bus.CTpPGH = out_q[4];
  assign bus.CTmPGH = out_q[5];
  assign bus.BUSY   = busy_q;
  assign bus.GSEL   = gsel_q;
`ifdef CDU_SCHED_OVF_EN
  assign bus.AOVF   = ovf_q[0];
  assign bus.BOVF   = ovf_q[1];
  assign bus.COVF   = ovf_q[2];
`endif
endmodule

// File: tb/tb_cdu_pulse_scheduler.sv
// Scoreboard bench for cdu_pulse_scheduler: stimulus pushes expected pulses, a negedge monitor
// pops and checks channel, sign, start cycle, width, GSEL, BUSY and exclusivity.
module tb_cdu_pulse_scheduler;
  localparam int PW = 4;
  localparam logic [5:0] AP = 6'b100000, AM = 6'b010000, BP = 6'b001000,
                         BM = 6'b000100, CP = 6'b000010, CM = 6'b000001;
  localparam logic [2:0] ZA = 3'b001, ZB = 3'b010, ZC = 3'b100;

  typedef struct {
    int ch;
    int neg;
    int start;
    int width;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  exp_t       exp_q[$];
  exp_t       cur;
  bit         in_pulse = 1'b0;
  int         run = 0;
  logic [5:0] prev_o = '0;
  logic [5:0] o;
  logic [5:0] ev;

  cdu_pulse_scheduler_if bus();

  cdu_pulse_scheduler #(.CW(4), .PULSE_W(PW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input logic sl, input logic [5:0] inc, input logic [2:0] z);
    bus.SLOTH = sl;
    {bus.ApINC, bus.AmINC, bus.BpINC, bus.BmINC, bus.CpINC, bus.CmINC} = inc;
    {bus.CCDUZ, bus.BCDUZ, bus.ACDUZ} = z;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0);
  endtask

  task automatic expect_pulse(input int ch, input int neg, input int start, input int width);
    exp_t e;
    e.ch = ch; e.neg = neg; e.start = start; e.width = width;
    exp_q.push_back(e);
  endtask

  // Strobe SLOTH for one cycle, expecting a full pulse to start next cycle.
  task automatic strobe_expect(input int ch, input int neg);
    expect_pulse(ch, neg, cyc + 1, PW);
    drive(1'b1, '0, '0);
  endtask

  task automatic check_outs_clear(input string name);
    check(name, int'({bus.CTmPGH, bus.CTpPGH, bus.BTmPGH, bus.BTpPGH, bus.ATmPGH, bus.ATpPGH}), 0);
    check({name, "_busy"}, int'(bus.BUSY), 0);
  endtask

  // Monitor: pops one expected entry per pulse start, measures width at the falling edge.
  always @(negedge clk) begin
    o = {bus.CTmPGH, bus.CTpPGH, bus.BTmPGH, bus.BTpPGH, bus.ATmPGH, bus.ATpPGH};
    check("busy_or", int'(bus.BUSY), int'(|o));
    check("onehot", int'($countones(o) <= 1), 1);
    if (o != '0 && prev_o == '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'(o), 0);
      end else begin
        cur = exp_q.pop_front();
        ev  = 6'(1) << (2 * cur.ch + cur.neg);
        check("pulse_sel", int'(o), int'(ev));
        check("pulse_start", cyc, cur.start);
        check("gsel", int'(bus.GSEL), cur.ch);
        in_pulse = 1'b1;
        run = 1;
      end
    end else if (o != '0) begin
      check("pulse_gap", int'(o), int'(prev_o));
      run++;
    end else if (prev_o != '0 && in_pulse) begin
      check("pulse_width", run, cur.width);
      in_pulse = 1'b0;
    end
    prev_o = o;
  end

  initial begin
    bus.SLOTH = 1'b0;
    {bus.ApINC, bus.AmINC, bus.BpINC, bus.BmINC, bus.CpINC, bus.CmINC} = '0;
    {bus.ACDUZ, bus.BCDUZ, bus.CCDUZ} = '0;

    // Reset state
    rst = 1'b1;
    idle(2);
    check_outs_clear("reset_outs");
    check("reset_gsel", int'(bus.GSEL), 0);
`ifdef CDU_SCHED_OVF_EN
    check("reset_ovf", int'({bus.COVF, bus.BOVF, bus.AOVF}), 0);
`endif
    rst = 1'b0;
    repeat (4) drive(1'b1, '0, '0);

    // Three A increments with SLOTH held high: grants at c0+1, c0+6, c0+11
    begin
      int c0;
      c0 = cyc;
      expect_pulse(0, 0, c0 + 2, PW);
      expect_pulse(0, 0, c0 + 7, PW);
      expect_pulse(0, 0, c0 + 12, PW);
      repeat (3) drive(1'b1, AP, '0);
      repeat (17) drive(1'b1, '0, '0);
      idle(2);
    end

    // Round-robin from reset: A, B, C then nothing
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    drive(1'b0, AP | BP | CP, '0);
    idle(2);
    strobe_expect(0, 0); idle(9);
    strobe_expect(1, 0); idle(9);
    strobe_expect(2, 0); idle(9);
    drive(1'b1, '0, '0); idle(9);

    // B saturates at -7; A zero leaves B alone; drain 7 minus pulses
    repeat (9) drive(1'b0, BM, '0);
`ifdef CDU_SCHED_OVF_EN
    check("bovf_set", int'(bus.BOVF), 1);
    check("aovf_clear", int'(bus.AOVF), 0);
`endif
    drive(1'b0, '0, ZA);
`ifdef CDU_SCHED_OVF_EN
    check("bovf_after_az", int'(bus.BOVF), 1);
`endif
    repeat (7) begin
      strobe_expect(1, 1);
      idle(5);
    end
    drive(1'b1, '0, '0); idle(5);
`ifdef CDU_SCHED_OVF_EN
    check("bovf_sticky", int'(bus.BOVF), 1);
`endif
    repeat (2) drive(1'b0, BM, '0);
    drive(1'b0, '0, ZB);
`ifdef CDU_SCHED_OVF_EN
    check("bovf_cleared", int'(bus.BOVF), 0);
`endif
    drive(1'b1, '0, '0); idle(5);

    // C plus and minus cancel: no pulse
    repeat (2) drive(1'b1, CP | CM, '0);
    repeat (3) drive(1'b1, '0, '0);
    idle(3);

    // Grant to A (P=+2) with ApINC same cycle: P stays +2, two more pulses follow
    repeat (2) drive(1'b0, AP, '0);
    expect_pulse(0, 0, cyc + 1, PW);
    drive(1'b1, AP, '0); idle(5);
    strobe_expect(0, 0); idle(5);
    strobe_expect(0, 0); idle(5);
    drive(1'b1, '0, '0); idle(5);

    // Zero A mid-pulse: pulse completes full width, P cleared
    repeat (2) drive(1'b0, AP, '0);
    strobe_expect(0, 0);
    drive(1'b0, '0, '0);
    drive(1'b0, '0, ZA);
    idle(3);
    drive(1'b1, '0, '0); idle(5);

    // Reset in the 2nd pulse cycle truncates it and clears accumulators
    repeat (2) drive(1'b0, AP, '0);
    expect_pulse(0, 0, cyc + 1, 2);
    drive(1'b1, '0, '0);
    drive(1'b0, '0, '0);
    rst = 1'b1;
    drive(1'b0, '0, '0);
    check_outs_clear("reset_mid_pulse");
    rst = 1'b0;
    idle(2);
    drive(1'b1, '0, '0); idle(5);

    // GSEL returns to 0 on reset after a C grant
    drive(1'b0, CP, '0);
    strobe_expect(2, 0); idle(5);
    check("gsel_c", int'(bus.GSEL), 2);
    rst = 1'b1;
    drive(1'b0, '0, ZC);
    rst = 1'b0;
    check("gsel_reset", int'(bus.GSEL), 0);
    idle(5);

    check("queue_empty", exp_q.size(), 0);
    check("no_pulse_open", int'(in_pulse), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
